// File: rtl/settings_memory_pkg.sv
// Shared communication-and-control parameters and address-map helpers for settings_memory.
package settings_memory_pkg;

  localparam int unsigned CAC_SETTINGS_MEMORY_WIDTH      = 32;
  localparam int unsigned CAC_SETTINGS_ROM_MEMORY_LENGTH = 16;
  localparam int unsigned CAC_SETTINGS_RAM_MEMORY_LENGTH = 16;
  localparam int unsigned CAC_CLK_FREQUENCY              = 100_000_000;

  // Fixed number of ROM source / RAM output ports on the block boundary.
  localparam int unsigned MaxWords = 16;

  typedef enum logic [1:0] {
    RegionRom,
    RegionRam,
    RegionUnmapped
  } region_e;

  function automatic int unsigned addr_width(input int unsigned rom_len,
                                             input int unsigned ram_len);
    return $clog2(rom_len + ram_len);
  endfunction

  function automatic region_e addr_region(input int unsigned addr,
                                          input int unsigned rom_len,
                                          input int unsigned ram_len);
    if (addr < rom_len) return RegionRom;
    if (addr < rom_len + ram_len) return RegionRam;
    return RegionUnmapped;
  endfunction

endpackage

// File: rtl/settings_memory_if.sv
// Host-side single-port access bus for settings_memory.
interface settings_memory_if #(
  parameter int unsigned MEMORY_WIDTH = 32,
  parameter int unsigned AW           = 5
) ();

  logic                    wen;
  logic [AW-1:0]           addr;
  logic [MEMORY_WIDTH-1:0] data_in;
  logic [MEMORY_WIDTH-1:0] data_out;

  modport master (output wen, output addr, output data_in, input data_out);
  modport slave  (input wen, input addr, input data_in, output data_out);

endinterface

// File: rtl/settings_read_mux.sv
// ROM/RAM/unmapped read decode; output is registered when SETTINGS_READ_REG_EN is defined.
module settings_read_mux
  import settings_memory_pkg::*;
#(
  parameter int unsigned MEMORY_WIDTH      = CAC_SETTINGS_MEMORY_WIDTH,
  parameter int unsigned ROM_MEMORY_LENGTH = CAC_SETTINGS_ROM_MEMORY_LENGTH,
  parameter int unsigned RAM_MEMORY_LENGTH = CAC_SETTINGS_RAM_MEMORY_LENGTH,
  parameter int unsigned AW                = 5
) (
`ifdef SETTINGS_READ_REG_EN
  input  logic                    clk,
`endif
  input  logic                    rstb,
  input  logic [AW-1:0]           addr_i,
  input  logic [MEMORY_WIDTH-1:0] rom_words_i [MaxWords],
  input  logic [MEMORY_WIDTH-1:0] ram_words_i [RAM_MEMORY_LENGTH],
  output logic [MEMORY_WIDTH-1:0] data_o
);

  logic [MEMORY_WIDTH-1:0] rd_d;

  always_comb begin
    rd_d = '0;
    unique case (addr_region(32'(addr_i), ROM_MEMORY_LENGTH, RAM_MEMORY_LENGTH))
      RegionRom: begin
        for (int unsigned i = 0; i < ROM_MEMORY_LENGTH; i++) begin
          if (addr_i == AW'(i)) rd_d = rom_words_i[i];
        end
      end
      RegionRam: begin
        for (int unsigned i = 0; i < RAM_MEMORY_LENGTH; i++) begin
          if (addr_i == AW'(ROM_MEMORY_LENGTH + i)) rd_d = ram_words_i[i];
        end
      end
      default: rd_d = '0;
    endcase
  end

`ifdef SETTINGS_READ_REG_EN
  logic [MEMORY_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) dout_q <= '0;
    else       dout_q <= rd_d;
  end

  assign data_o = dout_q;
`else
  // ROM words pass straight through, so reset must mask them explicitly.
  assign data_o = rstb ? rd_d : '0;
`endif

endmodule

// File: rtl/settings_memory.sv
// Flat settings store: read-only ROM window followed by a writable RAM bank with parallel outputs.
// Optional registered read path selected by the SETTINGS_READ_REG_EN macro.
module settings_memory
  import settings_memory_pkg::*;
#(
  parameter int unsigned MEMORY_WIDTH      = CAC_SETTINGS_MEMORY_WIDTH,
  parameter int unsigned ROM_MEMORY_LENGTH = CAC_SETTINGS_ROM_MEMORY_LENGTH,
  parameter int unsigned RAM_MEMORY_LENGTH = CAC_SETTINGS_RAM_MEMORY_LENGTH
) (
  input  logic                    clk,
  input  logic                    rstb,
  settings_memory_if.slave        bus,
  input  logic [MEMORY_WIDTH-1:0] rom_data_0,
  input  logic [MEMORY_WIDTH-1:0] rom_data_1,
  input  logic [MEMORY_WIDTH-1:0] rom_data_2,
  input  logic [MEMORY_WIDTH-1:0] rom_data_3,
  input  logic [MEMORY_WIDTH-1:0] rom_data_4,
  input  logic [MEMORY_WIDTH-1:0] rom_data_5,
  input  logic [MEMORY_WIDTH-1:0] rom_data_6,
  input  logic [MEMORY_WIDTH-1:0] rom_data_7,
  input  logic [MEMORY_WIDTH-1:0] rom_data_8,
  input  logic [MEMORY_WIDTH-1:0] rom_data_9,
  input  logic [MEMORY_WIDTH-1:0] rom_data_10,
  input  logic [MEMORY_WIDTH-1:0] rom_data_11,
  input  logic [MEMORY_WIDTH-1:0] rom_data_12,
  input  logic [MEMORY_WIDTH-1:0] rom_data_13,
  input  logic [MEMORY_WIDTH-1:0] rom_data_14,
  input  logic [MEMORY_WIDTH-1:0] rom_data_15,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_0,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_1,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_2,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_3,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_4,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_5,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_6,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_7,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_8,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_9,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_10,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_11,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_12,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_13,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_14,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_15
);

  localparam int unsigned AW = addr_width(ROM_MEMORY_LENGTH, RAM_MEMORY_LENGTH);

  logic [MEMORY_WIDTH-1:0] rom_words [MaxWords];
  logic [MEMORY_WIDTH-1:0] ram_q     [RAM_MEMORY_LENGTH];
  logic [MEMORY_WIDTH-1:0] ram_full  [MaxWords];

  assign rom_words[0]  = rom_data_0;
  assign rom_words[1]  = rom_data_1;
  assign rom_words[2]  = rom_data_2;
  assign rom_words[3]  = rom_data_3;
  assign rom_words[4]  = rom_data_4;
  assign rom_words[5]  = rom_data_5;
  assign rom_words[6]  = rom_data_6;
  assign rom_words[7]  = rom_data_7;
  assign rom_words[8]  = rom_data_8;
  assign rom_words[9]  = rom_data_9;
  assign rom_words[10] = rom_data_10;
  assign rom_words[11] = rom_data_11;
  assign rom_words[12] = rom_data_12;
  assign rom_words[13] = rom_data_13;
  assign rom_words[14] = rom_data_14;
  assign rom_words[15] = rom_data_15;

  // Writes outside the RAM region match no word and are dropped.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int unsigned i = 0; i < RAM_MEMORY_LENGTH; i++) ram_q[i] <= '0;
    end else if (bus.wen) begin
      for (int unsigned i = 0; i < RAM_MEMORY_LENGTH; i++) begin
        if (bus.addr == AW'(ROM_MEMORY_LENGTH + i)) ram_q[i] <= bus.data_in;
      end
    end
  end

  for (genvar gi = 0; gi < MaxWords; gi++) begin : g_ram_out
    if (gi < RAM_MEMORY_LENGTH) begin : g_live
      assign ram_full[gi] = ram_q[gi];
    end else begin : g_tie
      assign ram_full[gi] = '0;
    end
  end

  assign ram_data_out_0  = ram_full[0];
  assign ram_data_out_1  = ram_full[1];
  assign ram_data_out_2  = ram_full[2];
  assign ram_data_out_3  = ram_full[3];
  assign ram_data_out_4  = ram_full[4];
  assign ram_data_out_5  = ram_full[5];
  assign ram_data_out_6  = ram_full[6];
  assign ram_data_out_7  = ram_full[7];
  assign ram_data_out_8  = ram_full[8];
  assign ram_data_out_9  = ram_full[9];
  assign ram_data_out_10 = ram_full[10];
  assign ram_data_out_11 = ram_full[11];
  assign ram_data_out_12 = ram_full[12];
  assign ram_data_out_13 = ram_full[13];
  assign ram_data_out_14 = ram_full[14];
  assign ram_data_out_15 = ram_full[15];

  settings_read_mux #(
    .MEMORY_WIDTH     (MEMORY_WIDTH),
    .ROM_MEMORY_LENGTH(ROM_MEMORY_LENGTH),
    .RAM_MEMORY_LENGTH(RAM_MEMORY_LENGTH),
    .AW               (AW)
  ) u_read_mux (
`ifdef SETTINGS_READ_REG_EN
    .clk        (clk),
`endif
    .rstb       (rstb),
    .addr_i     (bus.addr),
    .rom_words_i(rom_words),
    .ram_words_i(ram_q),
    .data_o     (bus.data_out)
  );

endmodule

// File: tb/tb_settings_memory.sv
// Scoreboard bench for settings_memory: a full 16/16 instance and a 12/12 instance with unmapped space.
module tb_settings_memory;
  import settings_memory_pkg::*;

  localparam int unsigned HALF = 500_000_000 / CAC_CLK_FREQUENCY;

  typedef struct packed {
    logic [31:0]       dout_a;
    logic [31:0]       dout_b;
    logic [15:0][31:0] ram_a;
    logic [15:0][31:0] ram_b;
  } exp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #HALF clk = ~clk;

  settings_memory_if #(.MEMORY_WIDTH(32), .AW(5)) bus_a ();
  settings_memory_if #(.MEMORY_WIDTH(32), .AW(5)) bus_b ();

  logic [31:0]       rom_src [16];
  logic [15:0][31:0] ram_out_a;
  logic [15:0][31:0] ram_out_b;
  logic [15:0][31:0] m_ram_a;
  logic [15:0][31:0] m_ram_b;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  settings_memory #(
    .MEMORY_WIDTH(32), .ROM_MEMORY_LENGTH(16), .RAM_MEMORY_LENGTH(16)
  ) dut_a (
    .clk(clk), .rstb(rstb), .bus(bus_a),
    .rom_data_0(rom_src[0]),   .rom_data_1(rom_src[1]),   .rom_data_2(rom_src[2]),
    .rom_data_3(rom_src[3]),   .rom_data_4(rom_src[4]),   .rom_data_5(rom_src[5]),
    .rom_data_6(rom_src[6]),   .rom_data_7(rom_src[7]),   .rom_data_8(rom_src[8]),
    .rom_data_9(rom_src[9]),   .rom_data_10(rom_src[10]), .rom_data_11(rom_src[11]),
    .rom_data_12(rom_src[12]), .rom_data_13(rom_src[13]), .rom_data_14(rom_src[14]),
    .rom_data_15(rom_src[15]),
    .ram_data_out_0(ram_out_a[0]),   .ram_data_out_1(ram_out_a[1]),
    .ram_data_out_2(ram_out_a[2]),   .ram_data_out_3(ram_out_a[3]),
    .ram_data_out_4(ram_out_a[4]),   .ram_data_out_5(ram_out_a[5]),
    .ram_data_out_6(ram_out_a[6]),   .ram_data_out_7(ram_out_a[7]),
    .ram_data_out_8(ram_out_a[8]),   .ram_data_out_9(ram_out_a[9]),
    .ram_data_out_10(ram_out_a[10]), .ram_data_out_11(ram_out_a[11]),
    .ram_data_out_12(ram_out_a[12]), .ram_data_out_13(ram_out_a[13]),
    .ram_data_out_14(ram_out_a[14]), .ram_data_out_15(ram_out_a[15])
  );

  settings_memory #(
    .MEMORY_WIDTH(32), .ROM_MEMORY_LENGTH(12), .RAM_MEMORY_LENGTH(12)
  ) dut_b (
    .clk(clk), .rstb(rstb), .bus(bus_b),
    .rom_data_0(rom_src[0]),   .rom_data_1(rom_src[1]),   .rom_data_2(rom_src[2]),
    .rom_data_3(rom_src[3]),   .rom_data_4(rom_src[4]),   .rom_data_5(rom_src[5]),
    .rom_data_6(rom_src[6]),   .rom_data_7(rom_src[7]),   .rom_data_8(rom_src[8]),
    .rom_data_9(rom_src[9]),   .rom_data_10(rom_src[10]), .rom_data_11(rom_src[11]),
    .rom_data_12(rom_src[12]), .rom_data_13(rom_src[13]), .rom_data_14(rom_src[14]),
    .rom_data_15(rom_src[15]),
    .ram_data_out_0(ram_out_b[0]),   .ram_data_out_1(ram_out_b[1]),
    .ram_data_out_2(ram_out_b[2]),   .ram_data_out_3(ram_out_b[3]),
    .ram_data_out_4(ram_out_b[4]),   .ram_data_out_5(ram_out_b[5]),
    .ram_data_out_6(ram_out_b[6]),   .ram_data_out_7(ram_out_b[7]),
    .ram_data_out_8(ram_out_b[8]),   .ram_data_out_9(ram_out_b[9]),
    .ram_data_out_10(ram_out_b[10]), .ram_data_out_11(ram_out_b[11]),
    .ram_data_out_12(ram_out_b[12]), .ram_data_out_13(ram_out_b[13]),
    .ram_data_out_14(ram_out_b[14]), .ram_data_out_15(ram_out_b[15])
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference read: address map evaluated directly from the region boundaries.
  function automatic logic [31:0] model_read(input int a, input int rom_len, input int ram_len,
                                             input logic [15:0][31:0] ram);
    if (a < rom_len) return rom_src[a];
    if (a < rom_len + ram_len) return ram[a - rom_len];
    return 32'h0;
  endfunction

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d);
    bus_a.wen = w; bus_a.addr = a; bus_a.data_in = d;
    bus_b.wen = w; bus_b.addr = a; bus_b.data_in = d;
  endtask

  // One bus cycle: drive at the falling edge, record expected read (old contents) and new RAM.
  task automatic step(input logic w, input int a, input logic [31:0] d, input bit rnd_rom);
    exp_t e;
    @(negedge clk);
    if (rnd_rom) for (int i = 0; i < 16; i++) rom_src[i] = $urandom;
    drive(w, 5'(a), d);
    e.dout_a = model_read(a, 16, 16, m_ram_a);
    e.dout_b = model_read(a, 12, 12, m_ram_b);
    if (w && a >= 16 && a < 32) m_ram_a[a - 16] = d;
    if (w && a >= 12 && a < 24) m_ram_b[a - 12] = d;
    e.ram_a = m_ram_a;
    e.ram_b = m_ram_b;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] pre_a, pre_b, act_a, act_b;
    forever begin
      @(negedge clk);
      #(HALF - 1);
      pre_a = bus_a.data_out;
      pre_b = bus_b.data_out;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
`ifdef SETTINGS_READ_REG_EN
        act_a = bus_a.data_out;
        act_b = bus_b.data_out;
`else
        act_a = pre_a;
        act_b = pre_b;
`endif
        check("dout_a", 512'(act_a), 512'(e.dout_a));
        check("dout_b", 512'(act_b), 512'(e.dout_b));
        check("ram_a", 512'(ram_out_a), 512'(e.ram_a));
        check("ram_b", 512'(ram_out_b), 512'(e.ram_b));
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 16; i++) rom_src[i] = 32'(i);
    m_ram_a = '0;
    m_ram_b = '0;
    // Write attempted while held in reset must leave everything cleared.
    drive(1'b1, 5'd16, 32'hFF);
    bus_a.addr = 5'd5;
    bus_b.addr = 5'd5;
    repeat (10) @(posedge clk);
    #2;
    check("rst_ram_a", 512'(ram_out_a), 512'h0);
    check("rst_ram_b", 512'(ram_out_b), 512'h0);
    check("rst_dout_a", 512'(bus_a.data_out), 512'h0);
    check("rst_dout_b", 512'(bus_b.data_out), 512'h0);

    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0);
    rstb = 1'b1;
    repeat (30) @(posedge clk);

    step(1'b1, 16, 32'd16, 1'b0);
    step(1'b0, 16, 32'd0, 1'b0);
    for (int a = 0; a < 16; a++) step(1'b0, a, 32'd0, 1'b0);
    step(1'b1, 3, 32'hDEAD, 1'b0);
    step(1'b0, 3, 32'd0, 1'b0);
    step(1'b1, 31, 32'hA5, 1'b0);
    step(1'b0, 31, 32'd0, 1'b0);
    step(1'b1, 24, 32'h1234, 1'b0);
    step(1'b0, 24, 32'd0, 1'b0);
    step(1'b1, 12, 32'h5A5A, 1'b0);
    step(1'b0, 12, 32'd0, 1'b0);
    step(1'b1, 20, 32'h1111, 1'b0);
    step(1'b1, 20, 32'h2222, 1'b0);
    step(1'b0, 20, 32'd0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 7) == 0));
    end
    for (int a = 0; a < 32; a++) step(1'b0, a, 32'd0, 1'b0);

    // Asynchronous reset between edges clears outputs before any clock edge.
    @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    check("async_ram_a", 512'(ram_out_a), 512'h0);
    check("async_ram_b", 512'(ram_out_b), 512'h0);
    check("async_dout_a", 512'(bus_a.data_out), 512'h0);
    check("async_dout_b", 512'(bus_b.data_out), 512'h0);
    m_ram_a = '0;
    m_ram_b = '0;
    @(posedge clk);
    #2;
    rstb = 1'b1;
    step(1'b1, 17, 32'hCAFE, 1'b0);
    step(1'b0, 17, 32'd0, 1'b0);
    step(1'b0, 16, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 512'(q.size()), 512'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
